// File: rtl/sign_draw_ctrl.sv
// sign_draw_ctrl: walks the 1-bit sign bitmap ROM row-major and turns each
// bitmap bit into a coloured pixel write for the LCD printer, one pixel per
// valid/ready handshake.
//
// Optional build macro SIGN_TRANSPARENT_EN: when defined, bitmap-0 positions
// are skipped instead of being painted with the background colour.
module sign_draw_ctrl #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SIGN_W      = 16,
  parameter int SIGN_H      = 8,
  parameter int X_WIDTH     = 9,
  parameter int Y_WIDTH     = 8,
  parameter int COLOR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [X_WIDTH-1:0]     x0,
  input  logic [Y_WIDTH-1:0]     y0,
  input  logic [COLOR_WIDTH-1:0] fg_color,
  input  logic [COLOR_WIDTH-1:0] bg_color,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic                   rom_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [X_WIDTH-1:0]     pix_x,
  output logic [Y_WIDTH-1:0]     pix_y,
  output logic [COLOR_WIDTH-1:0] pix_color
);

  localparam int COL_W = $clog2(SIGN_W);
  localparam int ROW_W = $clog2(SIGN_H);
  localparam int CNT_W = COL_W + ROW_W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT,
    DONE
  } state_t;

  state_t state;

  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic [X_WIDTH-1:0]     x0_l;
  logic [Y_WIDTH-1:0]     y0_l;
  logic [COLOR_WIDTH-1:0] fg_l;
  logic                   last_pos;

`ifdef SIGN_TRANSPARENT_EN
  // Background colour is never painted in transparent mode.
  logic unused_bg;
  assign unused_bg = ^bg_color;
`else
  logic [COLOR_WIDTH-1:0] bg_l;
`endif

  // The ROM address is the scan position itself, {row, col} = row*SIGN_W+col,
  // so the bitmap bit for the current position is available in FETCH.
  assign rom_addr = {row, col};

  // Final bitmap position: the pixel that ends the sign.
  assign last_pos = (col == COL_W'(SIGN_W - 1)) && (row == ROW_W'(SIGN_H - 1));

  // Sequencer: latch the draw request, then alternate FETCH/EMIT per pixel
  // until the last position has been handed to the LCD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      col       <= '0;
      row       <= '0;
      x0_l      <= '0;
      y0_l      <= '0;
      fg_l      <= '0;
`ifndef SIGN_TRANSPARENT_EN
      bg_l      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x0_l  <= x0;
            y0_l  <= y0;
            fg_l  <= fg_color;
`ifndef SIGN_TRANSPARENT_EN
            bg_l  <= bg_color;
`endif
            col   <= '0;
            row   <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end

        FETCH: begin
`ifdef SIGN_TRANSPARENT_EN
          if (rom_data) begin
            pix_x     <= x0_l + X_WIDTH'(col);
            pix_y     <= y0_l + Y_WIDTH'(row);
            pix_color <= fg_l;
            pix_valid <= 1'b1;
            state     <= EMIT;
          end else if (last_pos) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            {row, col} <= {row, col} + CNT_W'(1);
          end
`else
          pix_x     <= x0_l + X_WIDTH'(col);
          pix_y     <= y0_l + Y_WIDTH'(row);
          pix_color <= rom_data ? fg_l : bg_l;
          pix_valid <= 1'b1;
          state     <= EMIT;
`endif
        end

        EMIT: begin
          if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
            if (last_pos) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              {row, col} <= {row, col} + CNT_W'(1);
              state      <= FETCH;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          pix_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_draw_ctrl.sv
// tb_sign_draw_ctrl: scoreboard bench for sign_draw_ctrl. Expected pixels are
// generated from the bench's own bitmap copy when a draw is started and are
// compared as the DUT hands them over.
module tb_sign_draw_ctrl;

  localparam int ADDR_WIDTH  = 7;
  localparam int SIGN_W      = 16;
  localparam int SIGN_H      = 8;
  localparam int X_WIDTH     = 9;
  localparam int Y_WIDTH     = 8;
  localparam int COLOR_WIDTH = 16;
  localparam int NPIX        = SIGN_W * SIGN_H;
  localparam int PW          = X_WIDTH + Y_WIDTH + COLOR_WIDTH;

`ifdef SIGN_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic [X_WIDTH-1:0]     x0;
  logic [Y_WIDTH-1:0]     y0;
  logic [COLOR_WIDTH-1:0] fg_color;
  logic [COLOR_WIDTH-1:0] bg_color;
  logic                   busy;
  logic                   done;
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic                   rom_data;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [X_WIDTH-1:0]     pix_x;
  logic [Y_WIDTH-1:0]     pix_y;
  logic [COLOR_WIDTH-1:0] pix_color;

  logic          rom_mem [0:NPIX-1];
  logic [PW-1:0] exp_q [$];
  int            num_checks;
  int            num_errors;
  int            accepted;

  sign_draw_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SIGN_W     (SIGN_W),
    .SIGN_H     (SIGN_H),
    .X_WIDTH    (X_WIDTH),
    .Y_WIDTH    (Y_WIDTH),
    .COLOR_WIDTH(COLOR_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .fg_color (fg_color),
    .bg_color (bg_color),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_color(pix_color)
  );

  // Combinational bitmap ROM
  assign rom_data = rom_mem[rom_addr];

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor: every valid pixel must match the head of the queue;
  // a held pixel is compared without popping, a handshake pops it.
  always @(negedge clk) begin
    if (rst_n && pix_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_pixel", 64'd1, 64'd0);
      end else if (pix_ready) begin
        checkOutput("pixel", 64'({pix_x, pix_y, pix_color}), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        accepted++;
      end else begin
        checkOutput("held_pixel", 64'({pix_x, pix_y, pix_color}), 64'(exp_q[0]));
      end
    end
  end

  // One full draw: push the model's pixels, pulse start, then step cycles
  // handling optional stall, ignored restart and mid-draw reset.
  task automatic applyStimulus(input string tag,
                               input logic [X_WIDTH-1:0] nx0, input logic [Y_WIDTH-1:0] ny0,
                               input logic [COLOR_WIDTH-1:0] nfg, input logic [COLOR_WIDTH-1:0] nbg,
                               input int stall_idx, input int stall_len,
                               input int restart_idx, input int abort_idx);
    int exp_cycles;
    int exp_count;
    int cycle;
    int stall_cnt;
    bit stall_active;
    bit stall_done;
    bit restart_sent;
    bit restart_hold;
    bit aborted;
    bit got_done;
    exp_cycles   = 1 + stall_len;
    exp_count    = 0;
    stall_active = 0;
    stall_done   = 0;
    restart_sent = 0;
    restart_hold = 0;
    aborted      = 0;
    got_done     = 0;
    accepted     = 0;
    for (int a = 0; a < NPIX; a++) begin
      logic [X_WIDTH-1:0] ex;
      logic [Y_WIDTH-1:0] ey;
      ex = nx0 + X_WIDTH'(a % SIGN_W);
      ey = ny0 + Y_WIDTH'(a / SIGN_W);
      if (rom_mem[a] || !TRANSP) begin
        exp_q.push_back({ex, ey, rom_mem[a] ? nfg : nbg});
        exp_count++;
        exp_cycles += 2;
      end else begin
        exp_cycles += 1;
      end
    end
    x0       = nx0;
    y0       = ny0;
    fg_color = nfg;
    bg_color = nbg;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycle = 1;
    checkOutput({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    while (cycle < 2000) begin
      if (aborted) begin
        checkOutput({tag, "_abort_valid"}, 64'(pix_valid), 64'd0);
        checkOutput({tag, "_abort_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_abort_done"}, 64'(done), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        break;
      end
      if (done) begin
        got_done = 1;
        break;
      end
      if (restart_hold) begin
        start        = 1'b0;
        restart_hold = 0;
      end
      if (stall_active) begin
        stall_cnt--;
        if (stall_cnt == 0) begin
          pix_ready    = 1'b1;
          stall_active = 0;
        end
      end else if (!stall_done && stall_idx >= 0 && pix_valid && accepted == stall_idx) begin
        pix_ready    = 1'b0;
        stall_cnt    = stall_len;
        stall_active = 1;
        stall_done   = 1;
      end
      if (!restart_sent && restart_idx >= 0 && accepted == restart_idx) begin
        x0           = nx0 ^ 9'h0AA;
        y0           = ny0 ^ 8'h33;
        fg_color     = ~nfg;
        bg_color     = ~nbg;
        start        = 1'b1;
        restart_sent = 1;
        restart_hold = 1;
      end
      if (!aborted && abort_idx >= 0 && accepted == abort_idx) begin
        rst_n   = 1'b0;
        aborted = 1;
      end
      @(posedge clk); #1;
      cycle++;
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    if (abort_idx >= 0) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        checkOutput({tag, "_no_done_after_abort"}, 64'(done | busy | pix_valid), 64'd0);
      end
    end else if (!got_done) begin
      checkOutput({tag, "_timeout"}, 64'(cycle), 64'(exp_cycles));
      exp_q.delete();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      checkOutput({tag, "_done_cycle"}, 64'(cycle), 64'(exp_cycles));
      checkOutput({tag, "_busy_in_done"}, 64'(busy), 64'd1);
      checkOutput({tag, "_pixel_count"}, 64'(accepted), 64'(exp_count));
      checkOutput({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      checkOutput({tag, "_idle_after_done"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_start_in_done_ignored"}, 64'(busy | pix_valid), 64'd0);
    end
  endtask

  // Main sequence
  initial begin
    num_checks = 0;
    num_errors = 0;
    accepted   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    pix_ready  = 1'b1;
    x0         = '0;
    y0         = '0;
    fg_color   = '0;
    bg_color   = '0;
    for (int a = 0; a < NPIX; a++) rom_mem[a] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_valid", 64'(pix_valid), 64'd0);
    checkOutput("reset_rom_addr", 64'(rom_addr), 64'd0);
    checkOutput("reset_pix", 64'({pix_x, pix_y, pix_color}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_quiet", 64'(busy | done | pix_valid), 64'd0);
    end

    for (int a = 0; a < NPIX; a++) rom_mem[a] = (a % 2 == 0);
    applyStimulus("full", 9'd100, 8'd50, 16'hF800, 16'h001F, -1, 0, -1, -1);
    applyStimulus("stall", 9'd100, 8'd50, 16'hF800, 16'h001F, 2, 5, -1, -1);
    applyStimulus("abort", 9'd20, 8'd30, 16'h07E0, 16'h1234, -1, 0, 20, 40);
    applyStimulus("wrap", 9'h1F8, 8'hFC, 16'hABCD, 16'h5555, -1, 0, -1, -1);

    for (int a = 0; a < NPIX; a++) rom_mem[a] = 1'($urandom_range(0, 1));
    applyStimulus("random", 9'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 7, 3, -1, -1);

    for (int a = 0; a < NPIX; a++) rom_mem[a] = (a == 0) || (a == NPIX - 1);
    applyStimulus("sparse", 9'd40, 8'd60, 16'hFFE0, 16'h0011, -1, 0, -1, -1);

    for (int a = 0; a < NPIX; a++) rom_mem[a] = 1'b0;
    applyStimulus("blank", 9'd5, 8'd6, 16'h00FF, 16'h7BEF, -1, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
